// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder slice.
//   state_t           : responder FSM states (zero-fill, serving requests)
//   KSEG_MASK         : strips kseg0/kseg1 segment bits from a virtual address
//   DEFAULT_BASE_PHYS : default physical base of the memory window
package sram_responder_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam logic [31:0] KSEG_MASK         = 32'h1fff_ffff;
    localparam logic [31:0] DEFAULT_BASE_PHYS = 32'h1fc0_0000;

endpackage

// File: rtl/sram_byte_array.sv
// DEPTH x 32-bit synchronous word array with per-byte write enables and a
// registered, read-first output. Kept separate so a vendor block RAM can be
// dropped in with the same interface.
//   clk    : clock, all logic on posedge
//   rd_clr : synchronous clear of the output register (wins over en)
//   en     : access enable; reads always, writes lanes selected by wen
//   wen    : byte lane write enables, bit i covers wdata[8i+7:8i]
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data (contents before this cycle's write)
module sram_byte_array #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rd_clr,
    input  logic                  en,
    input  logic [3:0]            wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Non-blocking read of mem in the same edge as the write gives read-first.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the CPU inst_sram/data_sram interface.
// Decodes kseg0/kseg1 addresses into a physical window, serves reads and
// byte-lane writes with one-cycle latency, zero-fills the array after reset
// and latches the first out-of-range access.
//   clk        : clock
//   reset      : synchronous, active-high reset
//   sram_en    : access request this cycle
//   sram_wen   : byte write enables, 0000 = read
//   sram_addr  : virtual byte address, bits [1:0] ignored
//   sram_wdata : write data
//   sram_rdata : registered read data
//   init_busy  : high while the zero-fill runs
//   oor_err    : sticky out-of-range flag
//   oor_addr   : sram_addr of the first out-of-range access
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] BASE_PHYS  = DEFAULT_BASE_PHYS,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        init_busy,
    output logic        oor_err,
    output logic [31:0] oor_addr
);

    localparam int unsigned HI_LSB      = ADDR_WIDTH + 2;
    localparam state_t      RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic [31:0]           phys;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  unused_byte_offset;

    logic                  arr_en;
    logic [3:0]            arr_wen;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [31:0]           arr_wdata;
    logic                  arr_rd_clr;
    logic                  capture_oor;

    assign phys               = sram_addr & KSEG_MASK;
    assign in_range           = (phys[31:HI_LSB] == BASE_PHYS[31:HI_LSB]);
    assign idx                = phys[HI_LSB-1:2];
    assign unused_byte_offset = ^phys[1:0];

    assign init_busy = (state_q == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both the fill and CPU requests drive the single array port; the
    // state decides who owns it. rd_clr zeroes the output register on
    // reset, during the fill and on out-of-range requests.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arr_en      = 1'b0;
        arr_wen     = '0;
        arr_addr    = idx;
        arr_wdata   = sram_wdata;
        arr_rd_clr  = 1'b0;
        capture_oor = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                arr_en     = 1'b1;
                arr_wen    = '1;
                arr_addr   = cnt_q;
                arr_wdata  = '0;
                arr_rd_clr = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (sram_en) begin
                    if (in_range) begin
                        arr_en  = 1'b1;
                        arr_wen = sram_wen;
                    end else begin
                        arr_rd_clr  = 1'b1;
                        capture_oor = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        if (reset) begin
            arr_en      = 1'b0;
            arr_rd_clr  = 1'b1;
            capture_oor = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oor_err  <= 1'b0;
            oor_addr <= '0;
        end else if (capture_oor) begin
            oor_err <= 1'b1;
            if (!oor_err) begin
                oor_addr <= sram_addr;
            end
        end
    end

    sram_byte_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk    (clk),
        .rd_clr (arr_rd_clr),
        .en     (arr_en),
        .wen    (arr_wen),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .rdata  (sram_rdata)
    );

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

    logic        clk;
    logic        reset;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        init_busy;
    logic        oor_err;
    logic [31:0] oor_addr;

    int checks = 0;
    int errors = 0;
    int busy_cycles;

    logic [31:0] exp_q [$];

    sram_responder #(
        .ADDR_WIDTH (4),
        .BASE_PHYS  (32'h1fc0_0000),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .init_busy  (init_busy),
        .oor_err    (oor_err),
        .oor_addr   (oor_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, push its expected read data, then compare after the edge.
    task automatic req(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        logic [31:0] want;
        sram_en    = 1'b1;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
        exp_q.push_back(exp);
        tick();
        sram_en  = 1'b0;
        sram_wen = 4'b0000;
        want = exp_q.pop_front();
        check(tag, sram_rdata, want);
    endtask

    // Counts init_busy cycles from now until it drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset      = 1'b1;
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;

        // 1: reset, fill length, first read
        repeat (2) tick();
        check("reset_rdata", sram_rdata, 32'h0);
        check("reset_oor_err", {31'b0, oor_err}, 32'h0);
        check("reset_oor_addr", oor_addr, 32'h0);
        reset = 1'b0;
        count_busy(busy_cycles);
        check("busy_len", busy_cycles, 32'd16);
        check("busy_low", {31'b0, init_busy}, 32'h0);
        req("read_after_fill", 4'b0000, 32'hbfc0_0014, 32'h0, 32'h0000_0000);

        // 2: full write, kseg0 alias, ignored byte offset
        req("write_full", 4'b1111, 32'hbfc0_0014, 32'hdead_beef, 32'h0000_0000);
        req("read_kseg0", 4'b0000, 32'h9fc0_0014, 32'h0, 32'hdead_beef);
        req("read_offset", 4'b0000, 32'hbfc0_0017, 32'h0, 32'hdead_beef);

        // 3: single byte lane
        req("write_byte1", 4'b0010, 32'hbfc0_0014, 32'h0000_aa00, 32'hdead_beef);
        req("read_byte1", 4'b0000, 32'hbfc0_0014, 32'h0, 32'hdead_aaef);

        // 4: read-first, read-after-write, hold while idle
        req("write_rdfirst", 4'b1111, 32'hbfc0_0014, 32'h1234_5678, 32'hdead_aaef);
        req("read_new", 4'b0000, 32'hbfc0_0014, 32'h0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_hold", sram_rdata, 32'h1234_5678);
        end

        // 5: out-of-range write then read; first address kept
        req("oor_write", 4'b1111, 32'hbfc0_0040, 32'hcafe_f00d, 32'h0);
        check("oor_err_set", {31'b0, oor_err}, 32'h1);
        check("oor_addr_first", oor_addr, 32'hbfc0_0040);
        req("oor_read", 4'b0000, 32'hbfc0_0080, 32'h0, 32'h0);
        check("oor_addr_kept", oor_addr, 32'hbfc0_0040);
        req("no_alias_write", 4'b0000, 32'hbfc0_0000, 32'h0, 32'h0);
        req("word5_intact", 4'b0000, 32'hbfc0_0014, 32'h0, 32'h1234_5678);

        // 6: reset mid-fill restarts the full fill; busy requests dropped
        req("write_55", 4'b1111, 32'hbfc0_0014, 32'h0000_0055, 32'h1234_5678);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("oor_err_cleared", {31'b0, oor_err}, 32'h0);
        repeat (7) tick();
        check("busy_mid", {31'b0, init_busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sram_en   = 1'b1;
        sram_wen  = 4'b0000;
        sram_addr = 32'hbfc0_0040;
        count_busy(busy_cycles);
        sram_en = 1'b0;
        check("busy_restart_len", busy_cycles, 32'd16);
        check("busy_rdata", sram_rdata, 32'h0);
        check("busy_no_oor", {31'b0, oor_err}, 32'h0);
        check("busy_no_oor_addr", oor_addr, 32'h0);
        req("word5_cleared", 4'b0000, 32'hbfc0_0014, 32'h0, 32'h0);
        check("final_oor_err", {31'b0, oor_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the CPU's inst_sram/data_sram request interface: en, wen, addr, wdata in; rdata back one cycle later.
- Backs a synchronous word array with byte-lane write enables.
- Decodes kseg0/kseg1 addresses to a physical window and flags out-of-range accesses.
- Zero-fills the array after reset, so the CPU core can be simulated and integrated without a vendor RAM.
- One instance per port: one for instruction, one for data.

Parameters:
- ADDR_WIDTH, 16, word-index bits; DEPTH = 2**ADDR_WIDTH words (default 256 KB).
- BASE_PHYS, 32'h1fc00000, physical base of the window; must be aligned to DEPTH*4.
- INIT_CLEAR, 1, 1 = zero-fill the array after reset; 0 = skip the fill and be ready immediately.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sram_en  input  1  access request this cycle.
- sram_wen  input  4  byte write enables; bit i covers wdata[8i+7:8i]; 0000 = read.
- sram_addr  input  32  virtual byte address; bits [1:0] are ignored.
- sram_wdata  input  32  write data.
- sram_rdata  output  32  registered read data.
- init_busy  output  1  high while the zero-fill is in progress.
- oor_err  output  1  sticky flag: an out-of-range access occurred.
- oor_addr  output  32  sram_addr of the first out-of-range access.

Behaviour:
- Reset: sram_rdata=0, oor_err=0, oor_addr=0, fill counter=0.
  - FSM goes to CLEAR if INIT_CLEAR=1, otherwise READY.
  - init_busy = (state==CLEAR).
- Address decode:
  - phys = {3'b000, sram_addr[28:0]}.
  - in_range = (phys[31:ADDR_WIDTH+2] == BASE_PHYS[31:ADDR_WIDTH+2]).
  - idx = phys[ADDR_WIDTH+1:2].
- CLEAR state:
  - Each cycle writes mem[cnt] <= 0 and increments cnt.
  - When cnt==DEPTH-1 the FSM moves to READY on that edge.
  - init_busy is high for exactly DEPTH cycles after reset is released.
  - While busy, requests are dropped (no write, no oor capture) and sram_rdata <= 0.
- READY state, sram_en=1, in_range:
  - Lanes with wen[i]=1 take wdata's byte i; other lanes are unchanged.
  - sram_rdata <= the pre-write word at mem[idx] (read-first), one-cycle latency.
  - Pure reads return mem[idx] on the next edge.
- READY state, sram_en=1, !in_range:
  - No array write; sram_rdata <= 0.
  - oor_err <= 1; oor_addr <= sram_addr only when oor_err was 0 (first error is kept).
  - Cleared only by reset.
- sram_en=0: no access; sram_rdata holds its previous value.
- Back-to-back write then read of the same word: the read on the next cycle returns the new data. No bypass is needed because the write has completed at the edge.
- Reset mid-CLEAR: counter returns to 0 and the fill restarts for the full DEPTH cycles. Array contents are not otherwise reset.
- Reset always overrides a simultaneous request.
- No stall or ready signal exists: latency is fixed at 1 cycle, matching the CPU IF/MEM timing.

Decomposition:
- Shared package holds:
  - FSM state encoding: ST_CLEAR, ST_READY.
  - KSEG_MASK constant 32'h1fffffff.
  - Default BASE_PHYS constant.
- Natural sub-module: sram_byte_array (DEPTH x 32 array, 4 byte-lane write enables, registered read-first output). This keeps the array swappable for a vendor block RAM.
- The responder wrapper holds decode, the FSM and the error capture.

Test Plan:
All scenarios use ADDR_WIDTH=4 (DEPTH=16, 64-byte window at 0x1fc00000).
1. Reset for 2 cycles, release -> init_busy high for exactly 16 cycles then 0. Read 0xbfc00014 -> sram_rdata=0x00000000 one cycle later.
2. Write 0xdeadbeef with wen=1111 to 0xbfc00014, then read 0x9fc00014 (kseg0 alias) -> 0xdeadbeef. Reading 0xbfc00017 returns the same word.
3. Byte write wen=0010, wdata=0x0000aa00 to 0xbfc00014, then read -> 0xdeadaaef.
4. Write 0x12345678 wen=1111 to 0xbfc00014 -> sram_rdata after that edge=0xdeadaaef (read-first). Following read -> 0x12345678. Then drop en for 3 cycles -> sram_rdata stays 0x12345678.
5. Write to 0xbfc00040, then read 0xbfc00080 -> no array change, sram_rdata=0, oor_err=1, oor_addr=0xbfc00040 (first error kept).
6. Reset asserted at cycle 7 of CLEAR after a prior write of 0x55 -> init_busy restarts and stays high 16 full cycles, word reads 0 afterwards, oor_err=0. A request issued during busy leaves oor_err=0.
